fifo_wptr_ctrl: RTL and testbench

- Write-domain pointer and status controller for the asynchronous FIFO.
- Maintains the write pointer and addresses the dual-port RAM.
- Publishes a registered Gray-coded write pointer, which the read-domain 2-FF synchronizer receives.
- Derives full, almost-full, fill level and overflow from the read pointer after it has been synchronized into this clock domain.

---
 rtl/fifo_wptr_ctrl.sv | 88 ++++++++
 tb/tb_fifo_wptr_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wptr_ctrl.sv
// fifo_wptr_ctrl
// Write-side pointer and status controller for an asynchronous FIFO.
// Keeps the binary write pointer, which addresses the dual-port RAM, and
// publishes a registered Gray copy for the read-domain synchronizer. Full,
// almost-full, fill level and overflow are derived from the read pointer
// after it has been synchronized into this clock domain.
//
// Ports:
//   Clk            write-domain clock, rising edge
//   reset          asynchronous active-high reset
//   w_en           write request from the producer
//   rptr_sync      Gray read pointer, already synchronized into Clk domain
//   w_accept       RAM write enable (combinational, w_en & ~w_full)
//   waddr          RAM write address (low ADDR_W bits of binary pointer)
//   wptr_gray      registered Gray write pointer for the read domain
//   w_full         registered full flag
//   w_almost_full  registered, fill level >= AF_THRESH
//   w_level        registered fill level seen from the write side
//   w_overflow     sticky: a write was attempted while full
module fifo_wptr_ctrl #(
    parameter int ADDR_W    = 4,
    parameter int AF_THRESH = 12
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              w_en,
    input  logic [ADDR_W:0]   rptr_sync,
    output logic              w_accept,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W:0]   wptr_gray,
    output logic              w_full,
    output logic              w_almost_full,
    output logic [ADDR_W:0]   w_level,
    output logic              w_overflow
);

    localparam logic [ADDR_W:0] AF_LVL = AF_THRESH[ADDR_W:0];

    // Gray-to-binary as an XOR prefix running down from the MSB.
    function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
        logic [ADDR_W:0] b;
        b[ADDR_W] = g[ADDR_W];
        for (int i = ADDR_W - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [ADDR_W:0] wbin;
    logic [ADDR_W:0] wbin_next;
    logic [ADDR_W:0] wgray_next;
    logic [ADDR_W:0] rbin;
    logic [ADDR_W:0] level_next;
    logic [ADDR_W:0] rptr_full;

    assign w_accept   = w_en & ~w_full;
    assign wbin_next  = wbin + {{ADDR_W{1'b0}}, w_accept};
    assign wgray_next = wbin_next ^ (wbin_next >> 1);
    assign rbin       = gray2bin(rptr_sync);
    assign level_next = wbin_next - rbin;

    // In Gray code "one full lap ahead" means the top two bits are inverted
    // and the rest match, so full is checked without converting rptr_sync.
    assign rptr_full  = {~rptr_sync[ADDR_W:ADDR_W-1], rptr_sync[ADDR_W-2:0]};

    assign waddr = wbin[ADDR_W-1:0];

    // Pointer and status registers; all flags are evaluated against the
    // post-increment pointer so an accepted write is visible right after the edge.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            wbin          <= '0;
            wptr_gray     <= '0;
            w_full        <= 1'b0;
            w_almost_full <= 1'b0;
            w_level       <= '0;
            w_overflow    <= 1'b0;
        end else begin
            wbin          <= wbin_next;
            wptr_gray     <= wgray_next;
            w_full        <= (wgray_next == rptr_full);
            w_almost_full <= (level_next >= AF_LVL);
            w_level       <= level_next;
            w_overflow    <= w_overflow | (w_en & w_full);
        end
    end

endmodule

// File: tb/tb_fifo_wptr_ctrl.sv
module tb_fifo_wptr_ctrl;

    logic       Clk = 1'b0;
    logic       reset = 1'b1;
    logic       w_en = 1'b0;
    logic [4:0] rptr_sync = '0;
    logic       w_accept;
    logic [3:0] waddr;
    logic [4:0] wptr_gray;
    logic       w_full;
    logic       w_almost_full;
    logic [4:0] w_level;
    logic       w_overflow;

    fifo_wptr_ctrl #(.ADDR_W(4), .AF_THRESH(12)) dut (
        .Clk           (Clk),
        .reset         (reset),
        .w_en          (w_en),
        .rptr_sync     (rptr_sync),
        .w_accept      (w_accept),
        .waddr         (waddr),
        .wptr_gray     (wptr_gray),
        .w_full        (w_full),
        .w_almost_full (w_almost_full),
        .w_level       (w_level),
        .w_overflow    (w_overflow)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [3:0] waddr;
        logic [4:0] gray;
        logic       full;
        logic       af;
        logic [4:0] level;
        logic       ovf;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   m_wbin, m_rd;
    logic m_full, m_ovf;

    function automatic logic [4:0] gray(input int x);
        logic [4:0] b;
        b = x[4:0];
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wbin = 0;
        m_rd   = 0;
        m_full = 1'b0;
        m_ovf  = 1'b0;
        q.delete();
    endtask

    // Drive one cycle of stimulus, push the expected post-edge state, then
    // pop and compare it just after the edge.
    task automatic step(input logic en, input int rd);
        exp_t e;
        int   lvl;
        logic acc;
        w_en      = en;
        m_rd      = rd & 31;
        rptr_sync = gray(m_rd);
        #1;
        acc = en & ~m_full;
        chk("w_accept", {31'd0, w_accept}, {31'd0, acc});
        m_ovf  = m_ovf | (en & m_full);
        m_wbin = (m_wbin + int'(acc)) & 31;
        lvl    = (m_wbin - m_rd) & 31;
        m_full = (lvl == 16);
        e.waddr = m_wbin[3:0];
        e.gray  = gray(m_wbin);
        e.full  = m_full;
        e.af    = (lvl >= 12);
        e.level = lvl[4:0];
        e.ovf   = m_ovf;
        q.push_back(e);
        @(posedge Clk);
        #1;
        e = q.pop_front();
        chk("waddr",         {28'd0, waddr},         {28'd0, e.waddr});
        chk("wptr_gray",     {27'd0, wptr_gray},     {27'd0, e.gray});
        chk("w_full",        {31'd0, w_full},        {31'd0, e.full});
        chk("w_almost_full", {31'd0, w_almost_full}, {31'd0, e.af});
        chk("w_level",       {27'd0, w_level},       {27'd0, e.level});
        chk("w_overflow",    {31'd0, w_overflow},    {31'd0, e.ovf});
    endtask

    initial begin
        logic [4:0] prev_gray;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        reset = 1'b0;

        // A few writes, then asynchronous reset mid-cycle with no edge.
        for (int i = 0; i < 3; i++) step(1'b1, 0);
        w_en = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_waddr",   {28'd0, waddr},         32'd0);
        chk("rst_gray",    {27'd0, wptr_gray},     32'd0);
        chk("rst_full",    {31'd0, w_full},        32'd0);
        chk("rst_af",      {31'd0, w_almost_full}, 32'd0);
        chk("rst_level",   {27'd0, w_level},       32'd0);
        chk("rst_ovf",     {31'd0, w_overflow},    32'd0);
        w_en = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_hold_waddr", {28'd0, waddr},     32'd0);
        chk("rst_hold_gray",  {27'd0, wptr_gray}, 32'd0);
        reset = 1'b0;
        w_en  = 1'b0;
        model_reset();

        // Fill from empty with 16 writes.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 0);
            if (i == 0) chk("gray_seq1", {27'd0, wptr_gray}, 32'h01);
            if (i == 1) chk("gray_seq2", {27'd0, wptr_gray}, 32'h03);
            if (i == 2) chk("gray_seq3", {27'd0, wptr_gray}, 32'h02);
            if (i == 3) chk("gray_seq4", {27'd0, wptr_gray}, 32'h06);
            if (i == 10) chk("af_before_12", {31'd0, w_almost_full}, 32'd0);
            if (i == 11) chk("af_at_12", {31'd0, w_almost_full}, 32'd1);
        end
        chk("full_gray",  {27'd0, wptr_gray}, 32'h18);
        chk("full_level", {27'd0, w_level},   32'd16);
        chk("full_flag",  {31'd0, w_full},    32'd1);

        // Writes while full are dropped and set the sticky overflow.
        for (int i = 0; i < 3; i++) step(1'b1, 0);
        chk("ovf_waddr", {28'd0, waddr},     32'd0);
        chk("ovf_gray",  {27'd0, wptr_gray}, 32'h18);
        step(1'b0, 0);
        chk("ovf_sticky", {31'd0, w_overflow}, 32'd1);

        // Drain release via the synchronized read pointer.
        step(1'b0, 4);
        chk("drain_level", {27'd0, w_level}, 32'd12);
        chk("drain_full",  {31'd0, w_full},  32'd0);
        step(1'b0, 15);
        chk("drain_level2", {27'd0, w_level},       32'd1);
        chk("drain_af2",    {31'd0, w_almost_full}, 32'd0);

        // Wrap-around: preload wbin=31 with the read pointer tracking.
        reset = 1'b1;
        #1;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 31; i++) step(1'b1, i);
        chk("pre_wrap_gray", {27'd0, wptr_gray}, 32'h10);
        step(1'b1, 31);
        chk("wrap_gray",  {27'd0, wptr_gray}, 32'h00);
        chk("wrap_level", {27'd0, w_level},   32'd1);
        chk("wrap_full",  {31'd0, w_full},    32'd0);
        // Fill across the wrap: full when gray(15) faces gray(31).
        for (int i = 0; i < 15; i++) step(1'b1, 31);
        chk("wrapfull_flag",  {31'd0, w_full},  32'd1);
        chk("wrapfull_level", {27'd0, w_level}, 32'd16);
        step(1'b1, 31);

        // Random stress with a legal, lagging read pointer.
        for (int i = 0; i < 400; i++) begin
            int  rd;
            logic en;
            rd = m_rd;
            if ($urandom_range(0, 1) == 1 && ((m_wbin - rd) & 31) != 0) rd = (rd + 1) & 31;
            en = ($urandom_range(0, 99) < 70);
            prev_gray = wptr_gray;
            step(en, rd);
            chk("gray_hamming", {31'd0, ($countones(prev_gray ^ wptr_gray) <= 1)}, 32'd1);
            chk("level_max",    {31'd0, (w_level <= 5'd16)}, 32'd1);
            chk("accept_full",  {31'd0, (w_accept & w_full)}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
